ul_spectrum_readout: RTL and testbench

Capture-and-readout buffer on the output side of the user-logic signal-processing chain. It takes the processed two-samples-per-clock stream (y0/y0z pair, even sample first), stores one armed frame into block RAM, and presents it to the host side through a one-word-per-request read handshake. It is the reader/drain counterpart to the sample-feeding path that drives x0/x0z into the processing block.

---
 rtl/ul_spectrum_readout.sv | 246 ++++++++++++++++++++++++
 tb/tb_ul_spectrum_readout.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ul_spectrum_readout.sv
// ---------------------------------------------------------------------------
// ul_spectrum_readout
//
// Capture-and-readout buffer at the output of the user-logic processing
// chain. One armed frame of (y0, y0z) sample pairs, even sample first, is
// written into block RAM. The host then drains the frame one word per
// request through a registered read port with a latency of one cycle.
//
// Optional feature macro: READOUT_PEAK_EN
//    When defined, a tracker follows the largest unsigned sample of the
//    captured frame and publishes its value and sample index. When it is
//    not defined, there is no tracker logic and peak_val_o/peak_idx_o are
//    tied to 0.
//
// Ports
//    clk_i        system clock, rising edge
//    rst_i        synchronous active-high reset
//    y0_i         even sample of the incoming pair
//    y0z_i        odd sample of the incoming pair
//    valid_i      pair valid this cycle
//    sof_i        start of frame, qualified by valid_i
//    arm_i        pulse that arms capture of the next frame
//    rd_req_i     read request, one word per asserted cycle
//    rd_ack_o     read data valid, one cycle after an accepted request
//    rd_data_o    {y0z, y0} of the pair being read; holds between acks
//    done_o       a complete frame is readable
//    state_o      FSM state (0 idle, 1 armed, 2 capture, 3 done)
//    sof_err_o    sticky: sof seen in the middle of a capture
//    frame_cnt_o  number of frames fully read out, wraps at 16 bits
//    peak_val_o   largest sample of the last captured frame
//    peak_idx_o   sample index of that largest sample
// ---------------------------------------------------------------------------
module ul_spectrum_readout #(
   parameter int DEPTH_LOG2 = 9,
   parameter int DATA_W     = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [DATA_W-1:0]       y0_i,
   input  logic [DATA_W-1:0]       y0z_i,
   input  logic                    valid_i,
   input  logic                    sof_i,
   input  logic                    arm_i,
   input  logic                    rd_req_i,
   output logic                    rd_ack_o,
   output logic [2*DATA_W-1:0]     rd_data_o,
   output logic                    done_o,
   output logic [1:0]              state_o,
   output logic                    sof_err_o,
   output logic [15:0]             frame_cnt_o,
   output logic [DATA_W-1:0]       peak_val_o,
   output logic [DEPTH_LOG2:0]     peak_idx_o
);

   // state     | meaning
   // ----------+-------------------------------------------------------
   // S_IDLE    | nothing captured or frame drained; waits for arm_i
   // S_ARMED   | waits for a valid pair that carries sof_i
   // S_CAPTURE | writes every valid pair; last address ends the frame
   // S_DONE    | frame readable; host drains it with rd_req_i
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam int                    DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] ADDR_LAST = '1;
   localparam logic [DEPTH_LOG2-1:0] ADDR_ONE  = DEPTH_LOG2'(1);

   state_t                  state;
   logic [DEPTH_LOG2-1:0]   wr_addr;
   logic [DEPTH_LOG2-1:0]   rd_addr;
   logic                    done;
   logic                    sof_err;
   logic [15:0]             frame_cnt;
   logic                    rd_ack;
   logic [2*DATA_W-1:0]     rd_data;

   logic [2*DATA_W-1:0]     mem [0:DEPTH-1];

   logic                    wr_en;
   logic [DEPTH_LOG2-1:0]   wr_ptr;
   logic                    last_write;
   logic                    rd_accept;

   // A sof pair always lands at address 0, both when starting a frame from
   // ARMED and when restarting in the middle of a capture.
   assign wr_en      = valid_i && (((state == S_ARMED) && sof_i) || (state == S_CAPTURE));
   assign wr_ptr     = sof_i ? '0 : wr_addr;
   assign last_write = (state == S_CAPTURE) && valid_i && !sof_i && (wr_addr == ADDR_LAST);
   assign rd_accept  = (state == S_DONE) && rd_req_i;

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_ptr] <= {y0z_i, y0_i};
      end
   end

   // Output register of the RAM doubles as the read data port, so data only
   // moves on an accepted request and holds otherwise.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_data <= '0;
      end else if (rd_accept) begin
         rd_data <= mem[rd_addr];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= S_IDLE;
         wr_addr   <= '0;
         rd_addr   <= '0;
         done      <= 1'b0;
         sof_err   <= 1'b0;
         frame_cnt <= '0;
         rd_ack    <= 1'b0;
      end else begin
         rd_ack <= rd_accept;
         case (state)
            S_IDLE: begin
               if (arm_i) begin
                  state   <= S_ARMED;
                  sof_err <= 1'b0;
               end
            end

            S_ARMED: begin
               if (arm_i) begin
                  sof_err <= 1'b0;
               end
               if (valid_i && sof_i) begin
                  state   <= S_CAPTURE;
                  wr_addr <= ADDR_ONE;
               end
            end

            S_CAPTURE: begin
               if (valid_i) begin
                  if (sof_i) begin
                     sof_err <= 1'b1;
                     wr_addr <= ADDR_ONE;
                  end else if (last_write) begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                     rd_addr <= '0;
                     wr_addr <= '0;
                  end else begin
                     wr_addr <= wr_addr + ADDR_ONE;
                  end
               end
            end

            S_DONE: begin
               if (rd_req_i) begin
                  rd_addr <= rd_addr + ADDR_ONE;
               end
               // Arm takes priority over finishing the drain; the read issued
               // in the same cycle is still acknowledged through rd_accept.
               if (arm_i) begin
                  state   <= S_ARMED;
                  done    <= 1'b0;
                  sof_err <= 1'b0;
               end else if (rd_req_i && (rd_addr == ADDR_LAST)) begin
                  state     <= S_IDLE;
                  done      <= 1'b0;
                  frame_cnt <= frame_cnt + 16'd1;
               end
            end

            default: begin
               state <= S_IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign rd_ack_o    = rd_ack;
   assign rd_data_o   = rd_data;
   assign done_o      = done;
   assign state_o     = state;
   assign sof_err_o   = sof_err;
   assign frame_cnt_o = frame_cnt;

`ifdef READOUT_PEAK_EN
   logic [DATA_W-1:0]     trk_val;
   logic [DATA_W-1:0]     trk_val_nxt;
   logic [DEPTH_LOG2:0]   trk_idx;
   logic [DEPTH_LOG2:0]   trk_idx_nxt;
   logic [DATA_W-1:0]     cand_val;
   logic [DEPTH_LOG2:0]   cand_idx;
   logic [DATA_W-1:0]     peak_val;
   logic [DEPTH_LOG2:0]   peak_idx;

   // Best sample of the incoming pair: y0z wins only when strictly larger,
   // so equal samples resolve to the earlier (even) index.
   always_comb begin
      if (y0z_i > y0_i) begin
         cand_val = y0z_i;
         cand_idx = {wr_ptr, 1'b1};
      end else begin
         cand_val = y0_i;
         cand_idx = {wr_ptr, 1'b0};
      end
   end

   // A sof pair reloads the tracker instead of comparing, which also clears
   // any maximum left over from an abandoned partial frame.
   always_comb begin
      trk_val_nxt = trk_val;
      trk_idx_nxt = trk_idx;
      if (wr_en) begin
         if (sof_i || (cand_val > trk_val)) begin
            trk_val_nxt = cand_val;
            trk_idx_nxt = cand_idx;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         trk_val  <= '0;
         trk_idx  <= '0;
         peak_val <= '0;
         peak_idx <= '0;
      end else begin
         trk_val <= trk_val_nxt;
         trk_idx <= trk_idx_nxt;
         if (last_write) begin
            peak_val <= trk_val_nxt;
            peak_idx <= trk_idx_nxt;
         end
      end
   end

   assign peak_val_o = peak_val;
   assign peak_idx_o = peak_idx;
`else
   assign peak_val_o = '0;
   assign peak_idx_o = '0;
`endif

endmodule

// File: tb/tb_ul_spectrum_readout.sv
module tb_ul_spectrum_readout;

   localparam int DEPTH = 512;

`ifdef READOUT_PEAK_EN
   localparam bit PEAK_EN = 1'b1;
`else
   localparam bit PEAK_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [15:0] y0;
   logic [15:0] y0z;
   logic        valid;
   logic        sof;
   logic        arm;
   logic        rd_req;
   logic        rd_ack;
   logic [31:0] rd_data;
   logic        done;
   logic [1:0]  state;
   logic        sof_err;
   logic [15:0] frame_cnt;
   logic [15:0] peak_val;
   logic [9:0]  peak_idx;

   int checks;
   int failures;

   logic [31:0] exp_mem [DEPTH];

   ul_spectrum_readout #(
      .DEPTH_LOG2 (9),
      .DATA_W     (16)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .y0_i        (y0),
      .y0z_i       (y0z),
      .valid_i     (valid),
      .sof_i       (sof),
      .arm_i       (arm),
      .rd_req_i    (rd_req),
      .rd_ack_o    (rd_ack),
      .rd_data_o   (rd_data),
      .done_o      (done),
      .state_o     (state),
      .sof_err_o   (sof_err),
      .frame_cnt_o (frame_cnt),
      .peak_val_o  (peak_val),
      .peak_idx_o  (peak_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        arm;
      logic        valid;
      logic        sof;
      logic        rd_req;
      logic [15:0] y0;
      logic [15:0] y0z;
      logic [1:0]  exp_state;
      logic        exp_ack;
      logic        exp_done;
      logic        exp_sof_err;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pair_val(input int mode, input int k);
      logic [15:0] a;
      logic [15:0] b;
      if (mode == 0) begin
         a = 16'(2 * k);
         b = 16'(2 * k + 1);
      end else begin
         a = 16'h0100;
         b = 16'h0100;
         if (k == 37)  b = 16'h7FFF;
         if (k == 200) a = 16'h7FFF;
      end
      return {b, a};
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, "_state"},     state, 0);
      chk({tag, "_done"},      done, 0);
      chk({tag, "_rd_ack"},    rd_ack, 0);
      chk({tag, "_rd_data"},   rd_data, 0);
      chk({tag, "_sof_err"},   sof_err, 0);
      chk({tag, "_frame_cnt"}, frame_cnt, 0);
      chk({tag, "_peak_val"},  peak_val, 0);
      chk({tag, "_peak_idx"},  peak_idx, 0);
   endtask

   // Writes pairs k = first .. last_excl-1; k == 0 carries sof.
   task automatic write_frame(input int mode, input bit gapped, input int first, input int last_excl);
      logic [31:0] w;
      for (int k = first; k < last_excl; k++) begin
         w = pair_val(mode, k);
         @(negedge clk);
         valid = 1'b1;
         sof   = (k == 0);
         y0    = w[15:0];
         y0z   = w[31:16];
         exp_mem[k] = w;
         @(posedge clk); #1;
         if (last_excl == DEPTH && k == DEPTH - 2) begin
            chk("done_before_last", done, 0);
            chk("state_before_last", state, 2);
         end
         if (last_excl == DEPTH && k == DEPTH - 1) begin
            chk("done_after_last", done, 1);
            chk("state_after_last", state, 3);
         end
         if (gapped) begin
            @(negedge clk);
            valid = 1'b0;
            sof   = 1'b0;
            @(posedge clk); #1;
         end
      end
      @(negedge clk);
      valid = 1'b0;
      sof   = 1'b0;
   endtask

   task automatic read_frame(input bit gapped, input int n);
      int          got;
      int          cyc;
      bit          req;
      bit          have_last;
      logic [31:0] last;
      got = 0;
      cyc = 0;
      have_last = 1'b0;
      last = '0;
      while (got < n && cyc < 4 * n + 16) begin
         @(negedge clk);
         req = !gapped || ($urandom_range(0, 1) == 1);
         rd_req = req;
         @(posedge clk); #1;
         cyc++;
         if (req) begin
            chk($sformatf("rd_ack[%0d]", got), rd_ack, 1);
            chk($sformatf("rd_data[%0d]", got), rd_data, exp_mem[got]);
            last = exp_mem[got];
            have_last = 1'b1;
            got++;
         end else begin
            chk("rd_ack_no_req", rd_ack, 0);
            if (have_last) chk("rd_data_hold", rd_data, last);
         end
      end
      @(negedge clk);
      rd_req = 1'b0;
      chk("read_count", got, n);
      if (n == DEPTH) begin
         chk("state_after_drain", state, 0);
         chk("done_after_drain", done, 0);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst = 1'b1; y0 = '0; y0z = '0; valid = 1'b0; sof = 1'b0; arm = 1'b0; rd_req = 1'b0;

      vecs[0] = '{"idle_sof_ignored",   0, 1, 1, 0, 16'h1111, 16'h2222, 2'd0, 0, 0, 0};
      vecs[1] = '{"idle_rdreq_no_ack",  0, 0, 0, 1, 16'h0000, 16'h0000, 2'd0, 0, 0, 0};
      vecs[2] = '{"arm_to_armed",       1, 0, 0, 0, 16'h0000, 16'h0000, 2'd1, 0, 0, 0};
      vecs[3] = '{"armed_valid_no_sof", 0, 1, 0, 0, 16'h3333, 16'h4444, 2'd1, 0, 0, 0};
      vecs[4] = '{"armed_rdreq_no_ack", 0, 1, 0, 1, 16'h5555, 16'h6666, 2'd1, 0, 0, 0};
      vecs[5] = '{"armed_rearm",        1, 0, 0, 0, 16'h0000, 16'h0000, 2'd1, 0, 0, 0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check_reset("rst");

      // Control corner cases in IDLE and ARMED.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         arm = vecs[i].arm; valid = vecs[i].valid; sof = vecs[i].sof;
         rd_req = vecs[i].rd_req; y0 = vecs[i].y0; y0z = vecs[i].y0z;
         @(posedge clk); #1;
         chk({vecs[i].name, "_state"},   state,   vecs[i].exp_state);
         chk({vecs[i].name, "_ack"},     rd_ack,  vecs[i].exp_ack);
         chk({vecs[i].name, "_done"},    done,    vecs[i].exp_done);
         chk({vecs[i].name, "_sof_err"}, sof_err, vecs[i].exp_sof_err);
      end
      @(negedge clk);
      arm = 1'b0; valid = 1'b0; sof = 1'b0; rd_req = 1'b0;

      // Full frame, back-to-back reads.
      write_frame(0, 1'b0, 0, DEPTH);
      chk("ramp_peak_val", peak_val, PEAK_EN ? 64'd1023 : 64'd0);
      chk("ramp_peak_idx", peak_idx, PEAK_EN ? 64'd1023 : 64'd0);
      read_frame(1'b0, DEPTH);
      chk("frame_cnt_1", frame_cnt, 1);

      // Gapped writes and bursty reads.
      @(negedge clk); arm = 1'b1;
      @(posedge clk); #1;
      chk("arm_gapped_state", state, 1);
      @(negedge clk); arm = 1'b0;
      write_frame(0, 1'b1, 0, DEPTH);
      read_frame(1'b1, DEPTH);
      chk("frame_cnt_2", frame_cnt, 2);

      // Restart by sof in the middle of a capture.
      @(negedge clk); arm = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); arm = 1'b0;
      write_frame(0, 1'b0, 0, 100);
      @(negedge clk);
      valid = 1'b1; sof = 1'b1; y0 = 16'hAAAA; y0z = 16'h5555;
      exp_mem[0] = {16'h5555, 16'hAAAA};
      @(posedge clk); #1;
      chk("midsof_sof_err", sof_err, 1);
      chk("midsof_state", state, 2);
      @(negedge clk);
      valid = 1'b0; sof = 1'b0;
      write_frame(0, 1'b0, 1, DEPTH);
      chk("midsof_peak_val", peak_val, PEAK_EN ? 64'hAAAA : 64'd0);
      chk("midsof_peak_idx", peak_idx, 0);
      read_frame(1'b0, DEPTH);
      chk("midsof_sof_err_sticky", sof_err, 1);
      chk("frame_cnt_3", frame_cnt, 3);
      @(negedge clk); arm = 1'b1;
      @(posedge clk); #1;
      chk("arm_clears_sof_err", sof_err, 0);
      @(negedge clk); arm = 1'b0;

      // Peak frame, then abandon it with arm part way through the drain.
      write_frame(1, 1'b0, 0, DEPTH);
      chk("peak_val", peak_val, PEAK_EN ? 64'h7FFF : 64'd0);
      chk("peak_idx", peak_idx, PEAK_EN ? 64'd75 : 64'd0);
      read_frame(1'b0, 10);
      @(negedge clk); arm = 1'b1;
      @(posedge clk); #1;
      chk("done_arm_state", state, 1);
      chk("done_arm_done", done, 0);
      chk("done_arm_frame_cnt", frame_cnt, 3);
      @(negedge clk); arm = 1'b0;

      // Arm together with the final read: arm wins, read still acked.
      write_frame(0, 1'b0, 0, DEPTH);
      read_frame(1'b0, DEPTH - 1);
      @(negedge clk); arm = 1'b1; rd_req = 1'b1;
      @(posedge clk); #1;
      chk("arm_last_ack", rd_ack, 1);
      chk("arm_last_data", rd_data, exp_mem[DEPTH-1]);
      chk("arm_last_state", state, 1);
      chk("arm_last_frame_cnt", frame_cnt, 3);
      @(negedge clk); arm = 1'b0; rd_req = 1'b0;

      // Reset in the middle of a capture.
      write_frame(0, 1'b0, 0, 300);
      chk("pre_reset_state", state, 2);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check_reset("midrst");
      @(negedge clk); rst = 1'b0; valid = 1'b1; sof = 1'b1; y0 = 16'hBEEF; y0z = 16'hCAFE;
      @(posedge clk); #1;
      chk("unarmed_sof_state", state, 0);
      @(negedge clk); valid = 1'b0; sof = 1'b0; arm = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); arm = 1'b0;
      write_frame(0, 1'b0, 0, DEPTH);
      read_frame(1'b0, DEPTH);
      chk("frame_cnt_after_reset", frame_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
